// File: rtl/mem_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_unit
// Brief    : Memory-op reservation buffer with address generation. Holds
//            loads/stores until operands are ready, then issues addr=rs1+imm.
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_unit #(
    parameter int DEPTH           = 4,
    parameter int MEM_QUEUE_DEPTH = 8,
    parameter int IDX_W           = $clog2(MEM_QUEUE_DEPTH),
    parameter int PHYS_REG_BITS   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     disp_valid,
    input  logic [6:0]               disp_opcode,
    input  logic [31:0]              disp_imm,
    input  logic [IDX_W-1:0]         disp_mem_idx,
    input  logic [PHYS_REG_BITS-1:0] disp_ps1,
    input  logic                     disp_ps1_rdy,
    input  logic [31:0]              disp_ps1_v,
    input  logic [PHYS_REG_BITS-1:0] disp_ps2,
    input  logic                     disp_ps2_rdy,
    input  logic [31:0]              disp_ps2_v,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_BITS-1:0] cdb_pd,
    input  logic [31:0]              cdb_rd_v,
    output logic                     full,
    output logic [31:0]              addr,
    output logic                     addr_valid,
    output logic [IDX_W-1:0]         mem_idx,
    output logic [31:0]              store_wdata,
    output logic [31:0]              rs1_rdata,
    output logic [31:0]              rs2_rdata
);

    localparam logic [6:0] C_OP_B_STORE = 7'b0100011;
    localparam int         C_SEL_W      = $clog2(DEPTH);

    typedef struct packed {
        logic                     valid;
        logic                     is_store;
        logic [31:0]              imm;
        logic [IDX_W-1:0]         mem_idx;
        logic [PHYS_REG_BITS-1:0] ps1;
        logic                     rdy1;
        logic [31:0]              v1;
        logic [PHYS_REG_BITS-1:0] ps2;
        logic                     rdy2;
        logic [31:0]              v2;
    } entry_t;

    entry_t [DEPTH-1:0] ent_q, ent_d;

    logic               addr_valid_q, addr_valid_d;
    logic [31:0]        addr_q, addr_d;
    logic [IDX_W-1:0]   mem_idx_q, mem_idx_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;

    logic [DEPTH-1:0]   w_valid_vec;
    logic               w_sel_found;
    logic [C_SEL_W-1:0] w_sel_idx;
    logic               w_free_found;
    logic [C_SEL_W-1:0] w_free_idx;
    entry_t             w_new_ent;

    function automatic logic cdb_hit(input logic [PHYS_REG_BITS-1:0] ps);
        return cdb_valid && (cdb_pd != '0) && (cdb_pd == ps);
    endfunction

    always_comb begin
        ent_d        = ent_q;
        addr_valid_d = 1'b0;
        addr_d       = addr_q;
        mem_idx_d    = mem_idx_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        w_valid_vec  = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;

        // Descending scans so the lowest matching index is the one left standing.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_valid_vec[i] = ent_q[i].valid;
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                w_sel_found = 1'b1;
                w_sel_idx   = C_SEL_W'(i);
            end
            if (!ent_q[i].valid) begin
                w_free_found = 1'b1;
                w_free_idx   = C_SEL_W'(i);
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && !ent_q[i].rdy1 && cdb_hit(ent_q[i].ps1)) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].v1   = cdb_rd_v;
            end
            if (ent_q[i].valid && !ent_q[i].rdy2 && cdb_hit(ent_q[i].ps2)) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].v2   = cdb_rd_v;
            end
        end

        if (w_sel_found) begin
            ent_d[w_sel_idx].valid = 1'b0;
            addr_valid_d           = 1'b1;
            addr_d                 = ent_q[w_sel_idx].v1 + ent_q[w_sel_idx].imm;
            mem_idx_d              = ent_q[w_sel_idx].mem_idx;
            rs1_d                  = ent_q[w_sel_idx].v1;
            rs2_d                  = ent_q[w_sel_idx].v2;
        end

        w_new_ent          = '0;
        w_new_ent.valid    = 1'b1;
        w_new_ent.is_store = (disp_opcode == C_OP_B_STORE);
        w_new_ent.imm      = disp_imm;
        w_new_ent.mem_idx  = disp_mem_idx;
        w_new_ent.ps1      = disp_ps1;
        w_new_ent.rdy1     = disp_ps1_rdy || cdb_hit(disp_ps1);
        w_new_ent.v1       = disp_ps1_rdy     ? disp_ps1_v :
                             cdb_hit(disp_ps1) ? cdb_rd_v   : 32'h0;
        w_new_ent.ps2      = disp_ps2;
        if (w_new_ent.is_store) begin
            w_new_ent.rdy2 = disp_ps2_rdy || cdb_hit(disp_ps2);
            w_new_ent.v2   = disp_ps2_rdy     ? disp_ps2_v :
                             cdb_hit(disp_ps2) ? cdb_rd_v   : 32'h0;
        end else begin
            w_new_ent.rdy2 = 1'b1;
            w_new_ent.v2   = 32'h0;
        end

        // Free slot comes from registered state, so a slot freed this cycle is not reused.
        if (disp_valid && w_free_found) begin
            ent_d[w_free_idx] = w_new_ent;
        end

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            addr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q        <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            mem_idx_q    <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else begin
            ent_q        <= ent_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            mem_idx_q    <= mem_idx_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
        end
    end

    assign full        = &w_valid_vec;
    assign addr        = addr_q;
    assign addr_valid  = addr_valid_q;
    assign mem_idx     = mem_idx_q;
    assign rs1_rdata   = rs1_q;
    assign rs2_rdata   = rs2_q;
    assign store_wdata = rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_addr_unit
// Brief    : Directed self-checking bench for mem_addr_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_addr_unit;

    localparam int IDX_W = 3;
    localparam int PRB   = 6;
    localparam logic [6:0] C_LOAD  = 7'b0000011;
    localparam logic [6:0] C_STORE = 7'b0100011;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic [6:0]       disp_opcode;
    logic [31:0]      disp_imm;
    logic [IDX_W-1:0] disp_mem_idx;
    logic [PRB-1:0]   disp_ps1;
    logic             disp_ps1_rdy;
    logic [31:0]      disp_ps1_v;
    logic [PRB-1:0]   disp_ps2;
    logic             disp_ps2_rdy;
    logic [31:0]      disp_ps2_v;
    logic             cdb_valid;
    logic [PRB-1:0]   cdb_pd;
    logic [31:0]      cdb_rd_v;
    logic             full;
    logic [31:0]      addr;
    logic             addr_valid;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      store_wdata;
    logic [31:0]      rs1_rdata;
    logic [31:0]      rs2_rdata;

    int checks = 0;
    int errors = 0;

    mem_addr_unit #(.DEPTH(4), .MEM_QUEUE_DEPTH(8), .IDX_W(IDX_W), .PHYS_REG_BITS(PRB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_imm(disp_imm),
        .disp_mem_idx(disp_mem_idx), .disp_ps1(disp_ps1), .disp_ps1_rdy(disp_ps1_rdy),
        .disp_ps1_v(disp_ps1_v), .disp_ps2(disp_ps2), .disp_ps2_rdy(disp_ps2_rdy),
        .disp_ps2_v(disp_ps2_v), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rd_v(cdb_rd_v),
        .full(full), .addr(addr), .addr_valid(addr_valid), .mem_idx(mem_idx),
        .store_wdata(store_wdata), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; disp_valid = 0; disp_opcode = C_LOAD; disp_imm = 0; disp_mem_idx = 0;
        disp_ps1 = 0; disp_ps1_rdy = 0; disp_ps1_v = 0;
        disp_ps2 = 0; disp_ps2_rdy = 0; disp_ps2_v = 0;
        cdb_valid = 0; cdb_pd = 0; cdb_rd_v = 0;
    endtask

    task automatic dispatch(input logic [6:0] op, input logic [31:0] imm, input logic [IDX_W-1:0] mi,
                            input logic [PRB-1:0] p1, input logic r1, input logic [31:0] v1,
                            input logic [PRB-1:0] p2, input logic r2, input logic [31:0] v2);
        disp_valid = 1; disp_opcode = op; disp_imm = imm; disp_mem_idx = mi;
        disp_ps1 = p1; disp_ps1_rdy = r1; disp_ps1_v = v1;
        disp_ps2 = p2; disp_ps2_rdy = r2; disp_ps2_v = v2;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #12;
        checks++;
        if (addr_valid !== 1'b0 || full !== 1'b0 || addr !== 32'h0 || mem_idx !== '0 ||
            store_wdata !== 32'h0 || rs1_rdata !== 32'h0 || rs2_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset: addr_valid=%b full=%b addr=%h mem_idx=%0d wd=%h rs1=%h rs2=%h required all 0",
                     addr_valid, full, addr, mem_idx, store_wdata, rs1_rdata, rs2_rdata);
        end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic test_load();
        dispatch(C_LOAD, 32'hFFFF_FFFC, 3'd2, 6'd3, 1, 32'h1000, 6'd4, 0, 32'h5555);
        tick();
        idle_inputs();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++; $display("FAIL load_early: addr_valid=%b required 0", addr_valid);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h0FFC || mem_idx !== 3'd2 ||
            store_wdata !== 32'h0 || rs2_rdata !== 32'h0 || rs1_rdata !== 32'h1000) begin
            errors++;
            $display("FAIL load_issue: v=%b addr=%h idx=%0d wd=%h rs1=%h rs2=%h required 1 0ffc 2 0 1000 0",
                     addr_valid, addr, mem_idx, store_wdata, rs1_rdata, rs2_rdata);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++; $display("FAIL load_pulse: addr_valid=%b required 0", addr_valid);
        end
    endtask

    task automatic test_store_wakeup();
        dispatch(C_STORE, 32'h8, 3'd5, 6'd5, 1, 32'h100, 6'd9, 0, 32'h0);
        tick();
        idle_inputs();
        cdb_valid = 1; cdb_pd = 6'd9; cdb_rd_v = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++; $display("FAIL store_early: addr_valid=%b required 0", addr_valid);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h108 || mem_idx !== 3'd5 ||
            store_wdata !== 32'hDEAD_BEEF || rs2_rdata !== 32'hDEAD_BEEF || rs1_rdata !== 32'h100) begin
            errors++;
            $display("FAIL store_issue: v=%b addr=%h idx=%0d wd=%h rs1=%h rs2=%h required 1 108 5 deadbeef 100 deadbeef",
                     addr_valid, addr, mem_idx, store_wdata, rs1_rdata, rs2_rdata);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            dispatch(C_LOAD, 32'h10, IDX_W'(i), PRB'(10 + i), 0, 32'h0, 6'd0, 0, 32'h0);
            tick();
        end
        dispatch(C_LOAD, 32'h0, 3'd7, 6'd1, 1, 32'h7777, 6'd0, 0, 32'h0);
        checks++;
        if (full !== 1'b1) begin
            errors++; $display("FAIL full_set: full=%b required 1", full);
        end
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (addr_valid !== 1'b0 || full !== 1'b1) begin
                errors++; $display("FAIL full_ignore: addr_valid=%b full=%b required 0 1", addr_valid, full);
            end
        end
        cdb_valid = 1; cdb_pd = 6'd12; cdb_rd_v = 32'h40;
        tick();
        idle_inputs();
        checks++;
        if (addr_valid !== 1'b0 || full !== 1'b1) begin
            errors++; $display("FAIL full_wake: addr_valid=%b full=%b required 0 1", addr_valid, full);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b1 || mem_idx !== 3'd2 || addr !== 32'h50 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_issue: v=%b idx=%0d addr=%h full=%b required 1 2 50 0",
                     addr_valid, mem_idx, addr, full);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++; $display("FAIL full_single: addr_valid=%b required 0", addr_valid);
        end
        flush = 1;
        tick();
        idle_inputs();
        checks++;
        if (full !== 1'b0) begin
            errors++; $display("FAIL full_flush: full=%b required 0", full);
        end
    endtask

    task automatic test_disp_bypass();
        dispatch(C_LOAD, 32'h4, 3'd1, 6'd7, 0, 32'h0, 6'd0, 0, 32'h0);
        cdb_valid = 1; cdb_pd = 6'd7; cdb_rd_v = 32'h20;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h24 || mem_idx !== 3'd1 || rs1_rdata !== 32'h20) begin
            errors++;
            $display("FAIL disp_bypass: v=%b addr=%h idx=%0d rs1=%h required 1 24 1 20",
                     addr_valid, addr, mem_idx, rs1_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [PRB-1:0] regs [4];
        regs[0] = 6'd20; regs[1] = 6'd0; regs[2] = 6'd22; regs[3] = 6'd20;
        for (int i = 0; i < 4; i++) begin
            dispatch(C_LOAD, 32'h100 * (i + 1), IDX_W'(i + 3), regs[i], 0, 32'h0, 6'd0, 0, 32'h0);
            tick();
        end
        idle_inputs();
        cdb_valid = 1; cdb_pd = 6'd0; cdb_rd_v = 32'h1234;
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (addr_valid !== 1'b0 || full !== 1'b1) begin
                errors++; $display("FAIL pd0_nowake: addr_valid=%b full=%b required 0 1", addr_valid, full);
            end
        end
        cdb_valid = 1; cdb_pd = 6'd20; cdb_rd_v = 32'h1000;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (addr_valid !== 1'b1 || mem_idx !== 3'd3 || addr !== 32'h1100) begin
            errors++;
            $display("FAIL b2b_first: v=%b idx=%0d addr=%h required 1 3 1100", addr_valid, mem_idx, addr);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b1 || mem_idx !== 3'd6 || addr !== 32'h1400) begin
            errors++;
            $display("FAIL b2b_second: v=%b idx=%0d addr=%h required 1 6 1400", addr_valid, mem_idx, addr);
        end
        tick();
        checks++;
        if (addr_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end: addr_valid=%b required 0", addr_valid);
        end
        flush = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush_reset();
        dispatch(C_LOAD, 32'h0, 3'd1, 6'd30, 0, 32'h0, 6'd0, 0, 32'h0);
        tick();
        dispatch(C_LOAD, 32'h0, 3'd2, 6'd31, 1, 32'h99, 6'd0, 0, 32'h0);
        tick();
        idle_inputs();
        flush = 1;
        dispatch(C_LOAD, 32'h0, 3'd4, 6'd1, 1, 32'h55, 6'd0, 0, 32'h0);
        tick();
        idle_inputs();
        checks++;
        if (addr_valid !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL flush_now: addr_valid=%b full=%b required 0 0", addr_valid, full);
        end
        cdb_valid = 1; cdb_pd = 6'd30; cdb_rd_v = 32'h1;
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (addr_valid !== 1'b0) begin
                errors++; $display("FAIL flush_after: addr_valid=%b required 0", addr_valid);
            end
        end
        dispatch(C_LOAD, 32'h8, 3'd3, 6'd2, 1, 32'h300, 6'd0, 0, 32'h0);
        tick();
        idle_inputs();
        tick();
        checks++;
        if (addr_valid !== 1'b1 || addr !== 32'h308) begin
            errors++; $display("FAIL rst_pre: v=%b addr=%h required 1 308", addr_valid, addr);
        end
        #2;
        rst = 0;
        #1;
        checks++;
        if (addr_valid !== 1'b0 || addr !== 32'h0 || full !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: v=%b addr=%h full=%b required 0 0 0", addr_valid, addr, full);
        end
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_wakeup();
        test_full();
        test_disp_bypass();
        test_back_to_back();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
